// File: rtl/display_scanner.sv
// Time-multiplexed 7-segment scan driver: shadow register, prescaler, GUARD/DRIVE per-digit FSM.
// Optional leading-zero blanking is enabled by defining DISP_LZB_EN.
module display_scanner #(
  parameter int NDIG        = 8,
  parameter int REFRESH_DIV = 50000,
  localparam int IW         = $clog2(NDIG),
  localparam int PW         = $clog2(REFRESH_DIV)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [4*NDIG-1:0] value,
  output logic              load_ack,
  output logic [3:0]        dig_val,
  output logic              dig_idle,
  output logic [NDIG-1:0]   an,
  output logic [IW-1:0]     scan_idx
);

  typedef enum logic {GUARD, DRIVE} state_t;

  state_t            state, state_next;
  logic [PW-1:0]     pcnt, pcnt_next;
  logic [IW-1:0]     idx_next;
  logic [4*NDIG-1:0] shadow;
  logic              valid;
  logic              ack_pend;
  logic              tick;
  logic [NDIG-1:0]   an_next;
  logic [NDIG-1:0]   blank;
  logic [3:0]        nib [NDIG];

  assign tick = (pcnt == PW'(REFRESH_DIV - 1));

  always_comb begin
    for (int unsigned i = 0; i < NDIG; i++) begin
      nib[i] = shadow[4*i +: 4];
    end
  end

  always_comb begin
    pcnt_next  = tick ? '0 : pcnt + PW'(1);
    idx_next   = scan_idx;
    state_next = state;
    if (tick) begin
      idx_next = (scan_idx == IW'(NDIG - 1)) ? '0 : scan_idx + IW'(1);
    end
    case (state)
      GUARD:   state_next = DRIVE;
      DRIVE:   state_next = tick ? GUARD : DRIVE;
      default: state_next = GUARD;
    endcase
    // Enables follow the upcoming state/index so the GUARD blank lines up with pcnt==0.
    an_next = '1;
    if (state_next == DRIVE) begin
      an_next[idx_next] = 1'b0;
    end
  end

`ifdef DISP_LZB_EN
  logic zero_run;
  always_comb begin
    zero_run = 1'b1;
    blank    = '0;
    for (int unsigned k = 0; k < NDIG; k++) begin
      zero_run = zero_run & (nib[NDIG-1-k] == 4'h0);
      blank[NDIG-1-k] = zero_run && ((NDIG - 1 - k) != 0);
    end
  end
`else
  assign blank = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= GUARD;
      pcnt     <= '0;
      scan_idx <= '0;
      shadow   <= '0;
      valid    <= 1'b0;
      ack_pend <= 1'b0;
      load_ack <= 1'b0;
      dig_val  <= '0;
      dig_idle <= 1'b1;
      an       <= '1;
    end else begin
      state    <= state_next;
      pcnt     <= pcnt_next;
      scan_idx <= idx_next;
      if (load) begin
        shadow <= value;
        valid  <= 1'b1;
      end
      ack_pend <= load;
      load_ack <= ack_pend;
      dig_val  <= nib[scan_idx];
      dig_idle <= ~valid | blank[scan_idx];
      an       <= an_next;
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// Directed self-checking bench for display_scanner with NDIG=4, REFRESH_DIV=4.
module tb_display_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic        load_ack;
  logic [3:0]  dig_val;
  logic        dig_idle;
  logic [3:0]  an;
  logic [1:0]  scan_idx;

  int tests = 0;
  int fails = 0;
  int t = 0;   // rising edges since the last reset edge

  display_scanner #(.NDIG(4), .REFRESH_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .value    (value),
    .load_ack (load_ack),
    .dig_val  (dig_val),
    .dig_idle (dig_idle),
    .an       (an),
    .scan_idx (scan_idx)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    t++;
  endtask

  task automatic test_reset();
    logic [3:0] an_tab  [16] = '{4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hF,
                                 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7, 4'hF};
    logic [1:0] idx_tab [16] = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 0};
    rst = 1'b1;
    step();
    step();
    t = 0;
    rst = 1'b0;
    tests++; if (an !== 4'hF) begin fails++; $display("FAIL reset_an got %h want f", an); end
    tests++; if (scan_idx !== 2'd0) begin fails++; $display("FAIL reset_idx got %0d want 0", scan_idx); end
    tests++; if (dig_idle !== 1'b1) begin fails++; $display("FAIL reset_idle got %b want 1", dig_idle); end
    tests++; if (dig_val !== 4'h0) begin fails++; $display("FAIL reset_val got %h want 0", dig_val); end
    tests++; if (load_ack !== 1'b0) begin fails++; $display("FAIL reset_ack got %b want 0", load_ack); end
    for (int i = 0; i < 16; i++) begin
      step();
      tests++; if (an !== an_tab[i]) begin fails++; $display("FAIL idle_an t=%0d got %h want %h", t, an, an_tab[i]); end
      tests++; if (scan_idx !== idx_tab[i]) begin fails++; $display("FAIL idle_idx t=%0d got %0d want %0d", t, scan_idx, idx_tab[i]); end
      tests++; if (dig_idle !== 1'b1) begin fails++; $display("FAIL idle_idle t=%0d got %b want 1", t, dig_idle); end
    end
  endtask

  task automatic test_load_latency();
    int acks = 0;
    step();
    step();                 // t=18: pcnt=2, slot 0
    load = 1'b1; value = 16'hA5C3;
    step();                 // capture edge
    load = 1'b0;
    acks += int'(load_ack);
    tests++; if (dig_idle !== 1'b1) begin fails++; $display("FAIL lat_idle_early got %b want 1", dig_idle); end
    step();                 // t=20
    acks += int'(load_ack);
    tests++; if (load_ack !== 1'b1) begin fails++; $display("FAIL lat_ack got %b want 1", load_ack); end
    tests++; if (dig_val !== 4'h3) begin fails++; $display("FAIL lat_val got %h want 3", dig_val); end
    tests++; if (dig_idle !== 1'b0) begin fails++; $display("FAIL lat_idle got %b want 0", dig_idle); end
    while (t < 32) begin
      step();
      acks += int'(load_ack);
      if (t == 21) begin
        tests++; if (dig_val !== 4'hC) begin fails++; $display("FAIL lat_slot1 got %h want c", dig_val); end
        tests++; if (an !== 4'hD) begin fails++; $display("FAIL lat_an1 got %h want d", an); end
      end
      if (t == 25) begin
        tests++; if (dig_val !== 4'h5) begin fails++; $display("FAIL lat_slot2 got %h want 5", dig_val); end
      end
      if (t == 29) begin
        tests++; if (dig_val !== 4'hA) begin fails++; $display("FAIL lat_slot3 got %h want a", dig_val); end
        tests++; if (dig_idle !== 1'b0) begin fails++; $display("FAIL lat_idle3 got %b want 0", dig_idle); end
      end
    end
    tests++; if (acks != 1) begin fails++; $display("FAIL lat_ack_count got %0d want 1", acks); end
  endtask

  task automatic test_load_at_tick();
    while (t < 39) step();  // t=39: pcnt=3, slot 1 (tick cycle)
    tests++; if (scan_idx !== 2'd1) begin fails++; $display("FAIL tick_pre_idx got %0d want 1", scan_idx); end
    load = 1'b1; value = 16'h1234;
    step();                 // t=40: slot 2 GUARD
    load = 1'b0;
    tests++; if (an !== 4'hF) begin fails++; $display("FAIL tick_guard_an got %h want f", an); end
    tests++; if (scan_idx !== 2'd2) begin fails++; $display("FAIL tick_idx got %0d want 2", scan_idx); end
    for (int i = 0; i < 3; i++) begin
      step();               // t=41..43: slot 2 DRIVE
      tests++; if (dig_val !== 4'h2) begin fails++; $display("FAIL tick_val t=%0d got %h want 2", t, dig_val); end
      tests++; if (an !== 4'hB) begin fails++; $display("FAIL tick_an t=%0d got %h want b", t, an); end
    end
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    load = 1'b1; value = 16'h1111;
    step();                 // t=44
    acks += int'(load_ack);
    value = 16'h2222;
    step();                 // t=45
    load = 1'b0;
    acks += int'(load_ack);
    tests++; if (dig_val !== 4'h1) begin fails++; $display("FAIL b2b_first got %h want 1", dig_val); end
    step();                 // t=46
    acks += int'(load_ack);
    tests++; if (dig_val !== 4'h2) begin fails++; $display("FAIL b2b_second got %h want 2", dig_val); end
    step();
    acks += int'(load_ack);
    step();                 // t=48
    acks += int'(load_ack);
    tests++; if (acks != 2) begin fails++; $display("FAIL b2b_ack_count got %0d want 2", acks); end
    tests++; if (dig_val !== 4'h2) begin fails++; $display("FAIL b2b_final got %h want 2", dig_val); end
  endtask

  task automatic test_lzb();
    logic [3:0] val_tab  [4] = '{4'h0, 4'h7, 4'h0, 4'h0};
`ifdef DISP_LZB_EN
    logic       idle_tab [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
`else
    logic       idle_tab [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    load = 1'b1; value = 16'h0070;
    step();                 // t=49
    load = 1'b0;
    while (t < 63) begin
      step();
      if (t % 4 == 2) begin
        tests++; if (dig_val !== val_tab[(t/4)%4]) begin fails++; $display("FAIL lzb_val digit=%0d got %h want %h", (t/4)%4, dig_val, val_tab[(t/4)%4]); end
        tests++; if (dig_idle !== idle_tab[(t/4)%4]) begin fails++; $display("FAIL lzb_idle digit=%0d got %b want %b", (t/4)%4, dig_idle, idle_tab[(t/4)%4]); end
      end
    end
  endtask

  task automatic test_reset_midscan();
    while (t < 75) step();  // t=75: pcnt=3, slot 2
    tests++; if (scan_idx !== 2'd2) begin fails++; $display("FAIL mid_pre_idx got %0d want 2", scan_idx); end
    rst = 1'b1; load = 1'b1; value = 16'hFFFF;
    step();
    t = 0;
    rst = 1'b0; load = 1'b0;
    tests++; if (an !== 4'hF) begin fails++; $display("FAIL mid_an got %h want f", an); end
    tests++; if (scan_idx !== 2'd0) begin fails++; $display("FAIL mid_idx got %0d want 0", scan_idx); end
    tests++; if (dig_idle !== 1'b1) begin fails++; $display("FAIL mid_idle got %b want 1", dig_idle); end
    step();
    tests++; if (an !== 4'hE) begin fails++; $display("FAIL mid_an1 got %h want e", an); end
    tests++; if (dig_idle !== 1'b1) begin fails++; $display("FAIL mid_idle1 got %b want 1", dig_idle); end
    tests++; if (dig_val !== 4'h0) begin fails++; $display("FAIL mid_val1 got %h want 0", dig_val); end
    step();
    tests++; if (load_ack !== 1'b0) begin fails++; $display("FAIL mid_ack got %b want 0", load_ack); end
    tests++; if (dig_idle !== 1'b1) begin fails++; $display("FAIL mid_idle2 got %b want 1", dig_idle); end
  endtask

  initial begin
    test_reset();
    test_load_latency();
    test_load_at_tick();
    test_back_to_back();
    test_lzb();
    test_reset_midscan();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
